// File: rtl/hack_loader_pkg.sv
// Shared types and constants for the Hack instruction-memory boot loader.
// Optional build macro: HACK_LOADER_CHECKSUM_EN adds the CHECK state to the state enum.
package hack_loader_pkg;

  localparam int               IMEM_WORDS = 32768;
  localparam int               WORD_W     = 16;
  localparam int               CHECKSUM_W = 8;
  localparam logic [15:0]      LEN_MIN    = 16'd0;
  localparam logic [15:0]      LEN_MAX    = 16'(IMEM_WORDS);

  // Encodings are fixed so both builds share the same values for common states.
  typedef enum logic [2:0] {
    ST_LEN_HI  = 3'd0,
    ST_LEN_LO  = 3'd1,
    ST_DATA_HI = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_WRITE   = 3'd4,
`ifdef HACK_LOADER_CHECKSUM_EN
    ST_CHECK   = 3'd5,
`endif
    ST_RUN     = 3'd6,
    ST_ERROR   = 3'd7
  } state_t;

  // A length that cannot fit in instruction memory.
  function automatic logic len_too_long(input logic [15:0] n);
    return n > LEN_MAX;
  endfunction

endpackage

// File: rtl/hack_word_assembler.sv
// Pairs hi/lo image bytes into 16-bit instruction words.
// word_valid pulses for one cycle after the lo byte is taken.
module hack_word_assembler
  import hack_loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        byte_data,
  input  logic              byte_take,
  input  logic              phase_lo,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [7:0]        r_hi;
  logic [WORD_W-1:0] r_word;
  logic              r_valid;

  // Latch the hi byte, then form the word when the lo byte arrives.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hi    <= 8'd0;
      r_word  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= byte_take & phase_lo;
      if (byte_take && !phase_lo) r_hi   <= byte_data;
      if (byte_take && phase_lo)  r_word <= {r_hi, byte_data};
    end
  end

  assign word       = r_word;
  assign word_valid = r_valid;

endmodule

// File: rtl/hack_imem_loader.sv
// Boot loader for the Hack CPU instruction memory: receives a length-prefixed
// big-endian image, writes it word by word, then releases the CPU.
// Optional build macro: HACK_LOADER_CHECKSUM_EN (trailing mod-256 checksum byte).
//
// state    | meaning
// ---------+--------------------------------------------------------
// LEN_HI   | waiting for word-count hi byte
// LEN_LO   | waiting for word-count lo byte; validates the count
// DATA_HI  | waiting for hi byte of next word
// DATA_LO  | waiting for lo byte of next word
// WRITE    | one-cycle imem write of the assembled word
// CHECK    | waiting for checksum byte (checksum builds only)
// RUN      | CPU running, imem address follows cpu_pc
// ERROR    | bad length or checksum; CPU held until load_req
module hack_imem_loader
  import hack_loader_pkg::*;
#(
  parameter bit BOOT_ON_RESET = 1'b1,
  parameter int ADDR_W        = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] cpu_pc,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_we,
  output logic [15:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error
);

`ifdef HACK_LOADER_CHECKSUM_EN
  localparam state_t ST_AFTER_DATA = ST_CHECK;
`else
  localparam state_t ST_AFTER_DATA = ST_RUN;
`endif

  state_t            r_state;
  state_t            w_next;
  logic              r_active;
  logic [7:0]        r_len_hi;
  logic [ADDR_W-1:0] r_idx;
  logic [15:0]       r_remaining;
  logic              r_done;
  logic              w_ready;
  logic              w_check;
  logic              w_take;
  logic [15:0]       w_len;
  logic [15:0]       w_word;
  logic              w_word_valid;
  logic              w_run;
`ifdef HACK_LOADER_CHECKSUM_EN
  logic [CHECKSUM_W-1:0] r_sum;
  assign w_check = (r_state == ST_CHECK);
`else
  assign w_check = 1'b0;
`endif

  assign w_ready = (r_state == ST_LEN_HI) || (r_state == ST_LEN_LO) ||
                   (r_state == ST_DATA_HI) || (r_state == ST_DATA_LO) || w_check;
  // r_active keeps every output at its reset value while reset is held,
  // even though r_state already shows the post-reset state.
  assign rx_ready = r_active & w_ready;
  assign w_take   = rx_valid & rx_ready;
  assign w_len    = {r_len_hi, rx_data};
  assign w_run    = r_active && (r_state == ST_RUN);

  hack_word_assembler u_asm (
    .clock      (clock),
    .reset      (reset),
    .byte_data  (rx_data),
    .byte_take  (w_take),
    .phase_lo   (r_state == ST_DATA_LO),
    .word       (w_word),
    .word_valid (w_word_valid)
  );

  // State register plus word index, remaining count, done flag and checksum.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= BOOT_ON_RESET ? ST_LEN_HI : ST_RUN;
      r_active    <= 1'b0;
      r_len_hi    <= 8'd0;
      r_idx       <= '0;
      r_remaining <= 16'd0;
      r_done      <= 1'b0;
`ifdef HACK_LOADER_CHECKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      r_active <= 1'b1;
      r_state  <= w_next;
      if (r_state == ST_LEN_HI && w_take) r_len_hi <= rx_data;
      if (r_state == ST_LEN_LO && w_take) begin
        r_idx       <= '0;
        r_remaining <= w_len;
      end
      if (r_state == ST_WRITE) begin
        r_idx       <= r_idx + ADDR_W'(1);
        r_remaining <= r_remaining - 16'd1;
      end
      if (w_next == ST_RUN && r_state != ST_RUN) r_done <= 1'b1;
      else if (w_next != ST_RUN)                 r_done <= 1'b0;
`ifdef HACK_LOADER_CHECKSUM_EN
      if (r_state == ST_LEN_LO && w_take) r_sum <= '0;
      else if ((r_state == ST_DATA_HI || r_state == ST_DATA_LO) && w_take)
        r_sum <= r_sum + rx_data;
`endif
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_LEN_HI:  if (w_take) w_next = ST_LEN_LO;
      ST_LEN_LO: begin
        if (w_take) begin
          if (w_len == LEN_MIN)        w_next = ST_AFTER_DATA;
          else if (len_too_long(w_len)) w_next = ST_ERROR;
          else                          w_next = ST_DATA_HI;
        end
      end
      ST_DATA_HI: if (w_take) w_next = ST_DATA_LO;
      ST_DATA_LO: if (w_take) w_next = ST_WRITE;
      ST_WRITE:   w_next = (r_remaining == 16'd1) ? ST_AFTER_DATA : ST_DATA_HI;
`ifdef HACK_LOADER_CHECKSUM_EN
      ST_CHECK:   if (w_take) w_next = (rx_data == r_sum) ? ST_RUN : ST_ERROR;
`endif
      ST_RUN, ST_ERROR: if (load_req) w_next = ST_LEN_HI;
      default:    w_next = ST_LEN_HI;
    endcase
  end

  assign imem_we    = w_word_valid && (r_state == ST_WRITE);
  assign imem_wdata = w_word;
  assign imem_addr  = w_run ? cpu_pc : r_idx;
  assign cpu_reset  = !w_run;
  assign load_done  = r_done;
  assign load_error = (r_state == ST_ERROR);

endmodule

// File: tb/tb_hack_imem_loader.sv
// Self-checking bench for hack_imem_loader (default BOOT_ON_RESET=1, ADDR_W=15).
// Honours HACK_LOADER_CHECKSUM_EN to match the build of the design.
module tb_hack_imem_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        load_req = 1'b0;
  logic [14:0] cpu_pc = 15'd0;
  logic [14:0] imem_addr;
  logic        imem_we;
  logic [15:0] imem_wdata;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;

`ifdef HACK_LOADER_CHECKSUM_EN
  localparam int NCKS = 1;
`else
  localparam int NCKS = 0;
`endif

  hack_imem_loader dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .load_req(load_req), .cpu_pc(cpu_pc),
    .imem_addr(imem_addr), .imem_we(imem_we), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .load_done(load_done), .load_error(load_error)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed { logic [14:0] a; logic [15:0] d; } wr_t;
  wr_t        wq[$];
  int         ready_in_write = 0;
  logic [15:0] words[$];
  logic [7:0]  img[$];

  // Record every memory write as the memory would see it.
  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      wq.push_back({imem_addr, imem_wdata});
      if (rx_ready !== 1'b0) ready_in_write++;
    end
  end

  // Reference image: length big-endian, words hi first, optional mod-256 byte sum.
  function automatic void make_image();
    int s;
    s = 0;
    img.delete();
    img.push_back(8'(words.size() >> 8));
    img.push_back(8'(words.size()));
    foreach (words[i]) begin
      img.push_back(words[i][15:8]);
      img.push_back(words[i][7:0]);
      s = s + int'(words[i][15:8]) + int'(words[i][7:0]);
    end
    if (NCKS == 1) img.push_back(8'(s % 256));
  endfunction

  task automatic random_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(16'($urandom));
  endtask

  task automatic send_byte(input logic [7:0] b, input int idle);
    bit got;
    int n;
    rx_valid = 1'b0;
    repeat (idle) begin @(posedge clock); #1; end
    rx_data = b;
    rx_valid = 1'b1;
    got = 1'b0;
    n = 0;
    while (!got && n < 40) begin
      @(negedge clock);
      got = (rx_ready === 1'b1);
      @(posedge clock);
      #1;
      n++;
    end
    rx_valid = 1'b0;
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL send_byte: byte %h not accepted, rx_ready=%b required 1", b, rx_ready);
    end
  endtask

  task automatic send_range(input int from, input int to, input int idle_max);
    for (int i = from; i < to; i++)
      send_byte(img[i], (idle_max > 0) ? int'($urandom_range(1, idle_max)) : 0);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      ok = (load_done === 1'b1);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    @(posedge clock);
    #1;
    load_req = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu_pc = 15'($urandom);
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_cmp += 7;
    if (rx_ready !== 1'b0)    begin n_fail++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
    if (imem_we !== 1'b0)     begin n_fail++; $display("FAIL reset_imem_we: got %b want 0", imem_we); end
    if (imem_addr !== 15'd0)  begin n_fail++; $display("FAIL reset_imem_addr: got %h want 0", imem_addr); end
    if (imem_wdata !== 16'd0) begin n_fail++; $display("FAIL reset_imem_wdata: got %h want 0", imem_wdata); end
    if (cpu_reset !== 1'b1)   begin n_fail++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
    if (load_done !== 1'b0)   begin n_fail++; $display("FAIL reset_load_done: got %b want 0", load_done); end
    if (load_error !== 1'b0)  begin n_fail++; $display("FAIL reset_load_error: got %b want 0", load_error); end
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_basic_load();
    bit ok;
    wq.delete();
    words.delete();
    words.push_back(16'h0055);
    words.push_back(16'hEC10);
    make_image();
    send_range(0, img.size() - NCKS, 0);
    n_cmp += 3;
    if (imem_we !== 1'b1)        begin n_fail++; $display("FAIL basic_write_latency: imem_we=%b want 1", imem_we); end
    if (imem_addr !== 15'd1)     begin n_fail++; $display("FAIL basic_last_addr: got %h want 1", imem_addr); end
    if (imem_wdata !== 16'hEC10) begin n_fail++; $display("FAIL basic_last_data: got %h want EC10", imem_wdata); end
    if (NCKS == 0) begin
      @(posedge clock);
      #1;
      n_cmp += 2;
      if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL basic_first_run_cpu_reset: got %b want 0", cpu_reset); end
      if (load_done !== 1'b1) begin n_fail++; $display("FAIL basic_first_run_done: got %b want 1", load_done); end
    end else begin
      send_range(img.size() - 1, img.size(), 0);
    end
    wait_done(ok);
    n_cmp += 3;
    if (!ok) begin n_fail++; $display("FAIL basic_done: load_done=%b want 1", load_done); end
    if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL basic_cpu_reset: got %b want 0", cpu_reset); end
    if (wq.size() != 2) begin n_fail++; $display("FAIL basic_write_count: got %0d want 2", wq.size()); end
    else begin
      n_cmp += 2;
      if (wq[0] !== {15'd0, 16'h0055}) begin n_fail++; $display("FAIL basic_write0: got %h want %h", wq[0], {15'd0, 16'h0055}); end
      if (wq[1] !== {15'd1, 16'hEC10}) begin n_fail++; $display("FAIL basic_write1: got %h want %h", wq[1], {15'd1, 16'hEC10}); end
    end
    for (int i = 0; i < 4; i++) begin
      logic [14:0] pc;
      pc = 15'($urandom);
      cpu_pc = pc;
      #1;
      n_cmp++;
      if (imem_addr !== pc) begin n_fail++; $display("FAIL basic_pc_passthrough: got %h want %h", imem_addr, pc); end
    end
  endtask

  task automatic test_len_error();
    bit ok;
    pulse_load_req();
    wq.delete();
    img.delete();
    img.push_back(8'h80);
    img.push_back(8'h01);
    send_range(0, 2, 0);
    n_cmp += 4;
    if (load_error !== 1'b1) begin n_fail++; $display("FAIL lenerr_error: got %b want 1", load_error); end
    if (cpu_reset !== 1'b1)  begin n_fail++; $display("FAIL lenerr_cpu_reset: got %b want 1", cpu_reset); end
    if (rx_ready !== 1'b0)   begin n_fail++; $display("FAIL lenerr_rx_ready: got %b want 0", rx_ready); end
    if (load_done !== 1'b0)  begin n_fail++; $display("FAIL lenerr_done: got %b want 0", load_done); end
    repeat (5) @(posedge clock);
    #1;
    n_cmp += 2;
    if (wq.size() != 0)      begin n_fail++; $display("FAIL lenerr_no_write: got %0d writes want 0", wq.size()); end
    if (load_error !== 1'b1) begin n_fail++; $display("FAIL lenerr_held: got %b want 1", load_error); end
    pulse_load_req();
    n_cmp++;
    if (load_error !== 1'b0) begin n_fail++; $display("FAIL lenerr_clear: got %b want 0", load_error); end
    random_words(1);
    make_image();
    send_range(0, img.size(), 0);
    wait_done(ok);
    n_cmp += 2;
    if (!ok) begin n_fail++; $display("FAIL lenerr_recover_done: load_done=%b want 1", load_done); end
    if (wq.size() != 1 || wq[0] !== {15'd0, words[0]})
      begin n_fail++; $display("FAIL lenerr_recover_write: got %0d writes first %h want %h", wq.size(), (wq.size() > 0) ? wq[0] : 31'd0, {15'd0, words[0]}); end
  endtask

  task automatic test_zero_len();
    bit ok;
    pulse_load_req();
    wq.delete();
    words.delete();
    make_image();
    send_range(0, img.size(), 0);
    wait_done(ok);
    n_cmp += 3;
    if (!ok) begin n_fail++; $display("FAIL zero_done: load_done=%b want 1", load_done); end
    if (cpu_reset !== 1'b0) begin n_fail++; $display("FAIL zero_cpu_reset: got %b want 0", cpu_reset); end
    if (wq.size() != 0) begin n_fail++; $display("FAIL zero_no_write: got %0d want 0", wq.size()); end
  endtask

  task automatic test_random_idle();
    bit ok;
    pulse_load_req();
    wq.delete();
    ready_in_write = 0;
    random_words(38);
    make_image();
    send_range(0, img.size(), 5);
    wait_done(ok);
    n_cmp += 3;
    if (!ok) begin n_fail++; $display("FAIL idle_done: load_done=%b want 1", load_done); end
    if (ready_in_write != 0) begin n_fail++; $display("FAIL idle_ready_in_write: got %0d cycles want 0", ready_in_write); end
    if (wq.size() != 38) begin n_fail++; $display("FAIL idle_write_count: got %0d want 38", wq.size()); end
    else begin
      for (int i = 0; i < 38; i++) begin
        n_cmp++;
        if (wq[i] !== {15'(i), words[i]}) begin n_fail++; $display("FAIL idle_write%0d: got %h want %h", i, wq[i], {15'(i), words[i]}); end
      end
    end
  endtask

  task automatic test_load_req_ignored();
    bit ok;
    pulse_load_req();
    wq.delete();
    random_words(3);
    make_image();
    send_range(0, 5, 0);
    pulse_load_req();
    n_cmp += 2;
    if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL ignore_cpu_reset: got %b want 1", cpu_reset); end
    if (rx_ready !== 1'b1)  begin n_fail++; $display("FAIL ignore_rx_ready: got %b want 1", rx_ready); end
    send_range(5, img.size(), 0);
    wait_done(ok);
    n_cmp += 2;
    if (!ok) begin n_fail++; $display("FAIL ignore_done: load_done=%b want 1", load_done); end
    if (wq.size() != 3) begin n_fail++; $display("FAIL ignore_write_count: got %0d want 3", wq.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (wq[i] !== {15'(i), words[i]}) begin n_fail++; $display("FAIL ignore_write%0d: got %h want %h", i, wq[i], {15'(i), words[i]}); end
      end
    end
    pulse_load_req();
    n_cmp += 2;
    if (cpu_reset !== 1'b1) begin n_fail++; $display("FAIL runreq_cpu_reset: got %b want 1", cpu_reset); end
    if (load_done !== 1'b0) begin n_fail++; $display("FAIL runreq_done: got %b want 0", load_done); end
  endtask

  task automatic test_reset_midload();
    bit ok;
    wq.delete();
    random_words(5);
    make_image();
    send_range(0, 8, 0);
    @(posedge clock);
    #1;
    n_cmp++;
    if (wq.size() != 3) begin n_fail++; $display("FAIL midreset_partial: got %0d writes want 3", wq.size()); end
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    n_cmp += 6;
    if (rx_ready !== 1'b0)   begin n_fail++; $display("FAIL midreset_rx_ready: got %b want 0", rx_ready); end
    if (imem_we !== 1'b0)    begin n_fail++; $display("FAIL midreset_imem_we: got %b want 0", imem_we); end
    if (imem_addr !== 15'd0) begin n_fail++; $display("FAIL midreset_imem_addr: got %h want 0", imem_addr); end
    if (cpu_reset !== 1'b1)  begin n_fail++; $display("FAIL midreset_cpu_reset: got %b want 1", cpu_reset); end
    if (load_done !== 1'b0)  begin n_fail++; $display("FAIL midreset_done: got %b want 0", load_done); end
    if (load_error !== 1'b0) begin n_fail++; $display("FAIL midreset_error: got %b want 0", load_error); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    wq.delete();
    random_words(5);
    make_image();
    send_range(0, img.size(), 0);
    wait_done(ok);
    n_cmp += 2;
    if (!ok) begin n_fail++; $display("FAIL midreset_reload_done: load_done=%b want 1", load_done); end
    if (wq.size() != 5) begin n_fail++; $display("FAIL midreset_write_count: got %0d want 5", wq.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        n_cmp++;
        if (wq[i] !== {15'(i), words[i]}) begin n_fail++; $display("FAIL midreset_write%0d: got %h want %h", i, wq[i], {15'(i), words[i]}); end
      end
    end
  endtask

`ifdef HACK_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bit ok;
    pulse_load_req();
    words.delete();
    words.push_back(16'h0102);
    words.push_back(16'h0304);
    make_image();
    img[img.size() - 1] = 8'h0A;
    send_range(0, img.size(), 0);
    wait_done(ok);
    n_cmp += 2;
    if (!ok) begin n_fail++; $display("FAIL cks_good_done: load_done=%b want 1", load_done); end
    if (load_error !== 1'b0) begin n_fail++; $display("FAIL cks_good_error: got %b want 0", load_error); end
    pulse_load_req();
    img[img.size() - 1] = 8'h0B;
    send_range(0, img.size(), 0);
    n_cmp += 3;
    if (load_error !== 1'b1) begin n_fail++; $display("FAIL cks_bad_error: got %b want 1", load_error); end
    if (cpu_reset !== 1'b1)  begin n_fail++; $display("FAIL cks_bad_cpu_reset: got %b want 1", cpu_reset); end
    if (load_done !== 1'b0)  begin n_fail++; $display("FAIL cks_bad_done: got %b want 0", load_done); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_load();
    test_len_error();
    test_zero_len();
    test_random_idle();
    test_load_req_ignored();
    test_reset_midload();
`ifdef HACK_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
